store_write_buffer: RTL and testbench

//  Sits directly downstream of the store data extractor (the block that zero-extends
//  rs2 to byte/half/word per funct3) and upstream of data memory.

---
 rtl/store_write_buffer.sv | 127 ++++++++++++
 tb/tb_store_write_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// Store write buffer: lane-aligns store data, builds byte enables and
// queues stores in a small FIFO drained to data memory by valid/ready.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [31:0]                st_data,
    input  logic [2:0]                 st_funct3,
    output logic                       st_misalign,
    output logic                       mem_req,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_be,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-3:0] addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        be_q   [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mis_q, mis_d;

    logic              legal;
    logic [3:0]        be_n;
    logic [31:0]       wd_n;
    logic              full, push, pop;
    logic              unused_ld;

    assign unused_ld = ^ld_addr[1:0];

    always_comb begin
        legal = 1'b0;
        be_n  = 4'b0000;
        wd_n  = 32'h0;
        case (st_funct3)
            3'b000: begin
                legal = 1'b1;
                be_n  = 4'b0001 << st_addr[1:0];
                wd_n  = {4{st_data[7:0]}};
            end
            3'b001: begin
                legal = ~st_addr[0];
                be_n  = 4'b0011 << st_addr[1:0];
                wd_n  = {2{st_data[15:0]}};
            end
            3'b010: begin
                legal = (st_addr[1:0] == 2'b00);
                be_n  = 4'b1111;
                wd_n  = st_data;
            end
            default: legal = 1'b0;
        endcase
    end

    // Full is judged on registered count, so a same-cycle pop never frees a slot.
    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign st_ready = ~full;
    assign push     = st_valid & st_ready & legal;
    assign pop      = ~empty & mem_ready;
    assign mis_d    = st_valid & st_ready & ~legal;

    always_comb begin
        wr_d  = push ? wr_q + PW'(1) : wr_q;
        rd_d  = pop  ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            mis_q <= 1'b0;
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            mis_q <= mis_d;
            if (pop)
                vld_q[rd_q] <= 1'b0;
            if (push) begin
                vld_q[wr_q]  <= 1'b1;
                addr_q[wr_q] <= st_addr[ADDR_W-1:2];
                data_q[wr_q] <= wd_n;
                be_q[wr_q]   <= be_n;
            end
        end
    end

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (vld_q[i] && addr_q[i] == ld_addr[ADDR_W-1:2])
                ld_hit = 1'b1;
    end

    assign st_misalign = mis_q;
    assign mem_req     = ~empty;
    assign mem_addr    = {addr_q[rd_q], 2'b00};
    assign mem_wdata   = data_q[rd_q];
    assign mem_be      = be_q[rd_q];
    assign count       = cnt_q;
endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: lane-format vector table
// plus directed sequences for full, wrap, load-hit and async reset.
module tb_store_write_buffer;
    logic        clk = 0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_misalign;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;

    store_write_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data),
        .st_funct3(st_funct3), .st_misalign(st_misalign),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .ld_addr(ld_addr),
        .ld_hit(ld_hit), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mis;
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] wd;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
    endtask

    logic [31:0] q [$];
    logic [31:0] hd;

    initial begin
        vt[0]  = '{3'b000, 32'h1003, 32'hA5F0B376, 0, 32'h1000, 4'b1000, 32'h76767676};
        vt[1]  = '{3'b000, 32'h1000, 32'h00000012, 0, 32'h1000, 4'b0001, 32'h12121212};
        vt[2]  = '{3'b000, 32'h1001, 32'hFFFFFF5A, 0, 32'h1000, 4'b0010, 32'h5A5A5A5A};
        vt[3]  = '{3'b001, 32'h2002, 32'h0000B376, 0, 32'h2000, 4'b1100, 32'hB376B376};
        vt[4]  = '{3'b001, 32'h2000, 32'hDEAD1234, 0, 32'h2000, 4'b0011, 32'h12341234};
        vt[5]  = '{3'b001, 32'h2001, 32'h0000B376, 1, 32'h0, 4'b0, 32'h0};
        vt[6]  = '{3'b001, 32'h2003, 32'h0000B376, 1, 32'h0, 4'b0, 32'h0};
        vt[7]  = '{3'b010, 32'h3000, 32'hCAFEF00D, 0, 32'h3000, 4'b1111, 32'hCAFEF00D};
        vt[8]  = '{3'b010, 32'h3002, 32'h11111111, 1, 32'h0, 4'b0, 32'h0};
        vt[9]  = '{3'b011, 32'h4000, 32'h22222222, 1, 32'h0, 4'b0, 32'h0};
        vt[10] = '{3'b100, 32'h4000, 32'h33333333, 1, 32'h0, 4'b0, 32'h0};

        rst_n = 0; st_valid = 0; st_addr = 0; st_data = 0;
        st_funct3 = 0; mem_ready = 0; ld_addr = 0;
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ready", 32'(st_ready), 1);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_mis", 32'(st_misalign), 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", 32'(mem_be), 0);
        rst_n = 1;
        step();

        for (int i = 0; i < 11; i++) begin
            mem_ready = 1'b0;
            offer(vt[i].f3, vt[i].addr, vt[i].data);
            step();
            st_valid = 1'b0;
            chk($sformatf("v%0d_mis", i), 32'(st_misalign), 32'(vt[i].mis));
            chk($sformatf("v%0d_cnt", i), 32'(count), vt[i].mis ? 0 : 1);
            chk($sformatf("v%0d_req", i), 32'(mem_req), vt[i].mis ? 0 : 1);
            if (!vt[i].mis) begin
                chk($sformatf("v%0d_addr", i), mem_addr, vt[i].waddr);
                chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(vt[i].be));
                chk($sformatf("v%0d_wd", i), mem_wdata, vt[i].wd);
            end
            mem_ready = 1'b1;
            step();
            chk($sformatf("v%0d_empty", i), 32'(empty), 1);
            chk($sformatf("v%0d_mis0", i), 32'(st_misalign), 0);
        end

        // T3: fill, reject while full, then ordered drain
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            offer(3'b010, 32'h10 + 32'(4*k), 32'(k+1));
            step();
            chk("t3_cnt", 32'(count), 32'(k+1));
        end
        chk("t3_full", 32'(st_ready), 0);
        offer(3'b010, 32'h20, 32'h5);
        step();
        st_valid = 1'b0;
        chk("t3_cnt5", 32'(count), 4);
        chk("t3_nomis", 32'(st_misalign), 0);
        chk("t3_hold_addr", mem_addr, 32'h10);
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_req", 32'(mem_req), 1);
            chk("t3_addr", mem_addr, 32'h10 + 32'(4*k));
            chk("t3_data", mem_wdata, 32'(k+1));
            if (k == 0) chk("t3_rdy_pop", 32'(st_ready), 0);
            step();
        end
        chk("t3_empty", 32'(empty), 1);
        step();
        chk("t3_no_uflow", 32'(count), 0);

        // T4: steady push+pop with pointer wrap, model queue
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            offer(3'b010, 32'h100 + 32'(4*k), 32'h100 + 32'(k));
            q.push_back(32'h100 + 32'(k));
            step();
        end
        chk("t4_cnt2", 32'(count), 2);
        mem_ready = 1'b1;
        for (int k = 2; k < 12; k++) begin
            offer(3'b010, 32'h100 + 32'(4*k), 32'h100 + 32'(k));
            hd = q.pop_front();
            chk("t4_head", mem_wdata, hd);
            q.push_back(32'h100 + 32'(k));
            step();
            chk("t4_cnt", 32'(count), 2);
        end
        st_valid = 1'b0;
        while (q.size() > 0) begin
            hd = q.pop_front();
            chk("t4_tail", mem_wdata, hd);
            step();
        end
        chk("t4_empty", 32'(empty), 1);

        // T5: load hit against buffered stores
        mem_ready = 1'b0;
        offer(3'b010, 32'h40, 32'h77);
        step();
        st_valid = 1'b0;
        ld_addr = 32'h42; #1;
        chk("t5_hit", 32'(ld_hit), 1);
        ld_addr = 32'h44; #1;
        chk("t5_miss", 32'(ld_hit), 0);
        offer(3'b010, 32'h44, 32'h88); #1;
        chk("t5_nobypass", 32'(ld_hit), 0);
        step();
        st_valid = 1'b0;
        chk("t5_hit2", 32'(ld_hit), 1);
        mem_ready = 1'b1;
        step();
        step();
        ld_addr = 32'h40; #1;
        chk("t5_empty_hit", 32'(ld_hit), 0);

        // T6: async reset mid-drain
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            offer(3'b010, 32'h60 + 32'(4*k), 32'h60 + 32'(k));
            step();
        end
        st_valid = 1'b0;
        chk("t6_cnt3", 32'(count), 3);
        mem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(mem_req), 0);
        chk("t6_cnt", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_addr", mem_addr, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_stay_empty", 32'(empty), 1);
        mem_ready = 1'b0;
        offer(3'b010, 32'h80, 32'h5555AAAA);
        step();
        st_valid = 1'b0;
        chk("t6_req2", 32'(mem_req), 1);
        chk("t6_addr2", mem_addr, 32'h80);
        chk("t6_wd2", mem_wdata, 32'h5555AAAA);
        mem_ready = 1'b1;
        step();
        chk("t6_drained", 32'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
